mem_access_unit: RTL

MEM-stage load/store unit of the pipelined CPU, placed between the EX/MEM pipeline register and `data_ram`. It converts byte-addressed RISC-V loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) into word-addressed RAM accesses. Sub-word stores are done as a two-cycle read-modify-write, with a pipeline stall during the read cycle. Loaded data is aligned and sign- or zero-extended for the MEM/WB register.

---
 rtl/mem_access_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: byte-addressed loads/stores onto a word-addressed data_ram.
// Sub-word stores run as a read-modify-write with one stall cycle.
//
//   state | meaning
//   IDLE  | accepting a new access; loads, SW and the RMW read cycle happen here
//   RMW   | write cycle of a sub-word store, merged word goes to the RAM
module mem_access_unit #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_write,
    input  logic [2:0]  mem_funct3,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [31:0] ram_dout,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_din,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        mem_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RMW  = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] rmw_buf;
    logic [1:0]  rmw_lane;
    logic        rmw_half;
    logic [15:0] rmw_data;

    logic        is_w, is_h, f3_bad, err_c, sub_store;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] merged;

    // Word index as data_ram decodes it; kept only as a debug reference, the RAM range-checks itself.
    logic [ADDR_WIDTH-1:0] unused_word_idx;
    assign unused_word_idx = mem_addr[ADDR_WIDTH+1:2];

    assign ram_addr = {2'b00, mem_addr[31:2]};

    assign is_w   = (mem_funct3 == 3'b010);
    assign is_h   = (mem_funct3[1:0] == 2'b01);
    assign f3_bad = (mem_funct3 == 3'b011) || (mem_funct3[2:1] == 2'b11);
    assign err_c  = mem_valid && (f3_bad
                                  || (is_w && (mem_addr[1:0] != 2'b00))
                                  || (is_h && mem_addr[0])
                                  || (mem_write && mem_funct3[2]));
    assign sub_store = mem_valid && mem_write && !err_c && !is_w;

    // Lane extraction from the RAM word for loads
    always_comb begin
        case (mem_addr[1:0])
            2'b00:   byte_sel = ram_dout[7:0];
            2'b01:   byte_sel = ram_dout[15:8];
            2'b10:   byte_sel = ram_dout[23:16];
            default: byte_sel = ram_dout[31:24];
        endcase
        half_sel = mem_addr[1] ? ram_dout[31:16] : ram_dout[15:0];
    end

    // Merge the captured store data into the word read during the first cycle
    always_comb begin
        merged = rmw_buf;
        if (rmw_half) begin
            if (rmw_lane[1]) merged[31:16] = rmw_data;
            else             merged[15:0]  = rmw_data;
        end else begin
            case (rmw_lane)
                2'b00:   merged[7:0]   = rmw_data[7:0];
                2'b01:   merged[15:8]  = rmw_data[7:0];
                2'b10:   merged[23:16] = rmw_data[7:0];
                default: merged[31:24] = rmw_data[7:0];
            endcase
        end
    end

    // State register plus capture of the read word and store lane for the RMW cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rmw_buf  <= '0;
            rmw_lane <= '0;
            rmw_half <= 1'b0;
            rmw_data <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && sub_store) begin
                rmw_buf  <= ram_dout;
                rmw_lane <= mem_addr[1:0];
                rmw_half <= is_h;
                rmw_data <= mem_wdata[15:0];
            end
        end
    end

    // Next-state and output decode; reset forces the RAM strobe and stall low immediately
    always_comb begin
        state_nxt = state;
        ram_we    = 1'b0;
        stall     = 1'b0;
        ram_din   = '0;
        load_data = '0;
        mem_err   = err_c;
        case (state)
            IDLE: begin
                if (mem_valid && !err_c) begin
                    if (mem_write) begin
                        if (is_w) begin
                            ram_we  = 1'b1;
                            ram_din = mem_wdata;
                        end else begin
                            stall     = 1'b1;
                            state_nxt = RMW;
                        end
                    end else if (is_w) begin
                        load_data = ram_dout;
                    end else if (is_h) begin
                        load_data = {{16{half_sel[15] & ~mem_funct3[2]}}, half_sel};
                    end else begin
                        load_data = {{24{byte_sel[7] & ~mem_funct3[2]}}, byte_sel};
                    end
                end
            end
            RMW: begin
                ram_we    = 1'b1;
                ram_din   = merged;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            ram_we    = 1'b0;
            stall     = 1'b0;
            ram_din   = '0;
            load_data = '0;
            mem_err   = 1'b0;
            state_nxt = IDLE;
        end
    end

endmodule
